// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/load stage: load-op encodings,
// FSM state encoding and small helpers.
package wb_pkg;

    localparam int XLEN  = 32;
    localparam int RIDXW = 5;

    localparam logic [2:0] LDOP_LW  = 3'b000;
    localparam logic [2:0] LDOP_LH  = 3'b001;
    localparam logic [2:0] LDOP_LHU = 3'b010;
    localparam logic [2:0] LDOP_LB  = 3'b011;
    localparam logic [2:0] LDOP_LBU = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wb_state_e;

    // Memory is word-addressed on the read port; lane selection happens on return.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian load data extraction: lane select plus sign/zero extension.
// Undefined ldop codes fall back to a full-word load.
module load_align
    import wb_pkg::*;
(
    input  logic [2:0]      ldop,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [15:0] lane_h;
    logic [7:0]  lane_b;

    always_comb begin
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (addr)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase

        case (ldop)
            LDOP_LH:  data = {{16{lane_h[15]}}, lane_h};
            LDOP_LHU: data = {16'h0000, lane_h};
            LDOP_LB:  data = {{24{lane_b[7]}}, lane_b};
            LDOP_LBU: data = {24'h000000, lane_b};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_load_stage.sv
// Writeback stage with a single outstanding data-memory load and a
// register-write bypass query. Bypass hits are enabled by WB_BYPASS_EN.
module wb_load_stage
    import wb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    // Handshake: a transfer happens on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and in_* are ignored whenever in_ready is low.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RIDXW-1:0] in_wr,
    input  logic [XLEN-1:0]  in_data,
    input  logic             in_regw,
    input  logic             in_load,
    input  logic [2:0]       in_ldop,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [RIDXW-1:0] wr,
    output logic [XLEN-1:0]  wdata,
    output logic             regw,
    output logic             pend,
    output logic [RIDXW-1:0] pend_reg,
    input  logic [RIDXW-1:0] r1,
    input  logic [RIDXW-1:0] r2,
    output logic             fwd1_hit,
    output logic             fwd2_hit,
    output wb_state_e        dbg_state
);

    wb_state_e       state, state_next;
    logic            accept;
    logic            ld_done;
    logic [2:0]      ld_op;
    logic [1:0]      ld_off;
    logic            ld_we;
    logic [XLEN-1:0] ld_data;

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        ld_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && in_load) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Return data may arrive as early as the mem_req cycle itself.
                if (mem_rvalid) begin
                    ld_done    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    load_align u_align (
        .ldop  (ld_op),
        .addr  (ld_off),
        .rdata (mem_rdata),
        .data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regw     <= 1'b0;
            wr       <= '0;
            wdata    <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            pend     <= 1'b0;
            pend_reg <= '0;
            ld_op    <= LDOP_LW;
            ld_off   <= 2'b00;
            ld_we    <= 1'b0;
        end else begin
            regw    <= 1'b0;
            mem_req <= 1'b0;
            if (accept && !in_load && in_regw && (in_wr != '0)) begin
                regw  <= 1'b1;
                wr    <= in_wr;
                wdata <= in_data;
            end
            if (accept && in_load) begin
                mem_req  <= 1'b1;
                mem_addr <= word_align(in_data);
                pend     <= 1'b1;
                pend_reg <= in_wr;
                ld_op    <= in_ldop;
                ld_off   <= in_data[1:0];
                ld_we    <= in_regw && (in_wr != '0);
            end
            // wr/wdata keep their last written value unless a write actually fires.
            if (ld_done) begin
                pend <= 1'b0;
                if (ld_we) begin
                    regw  <= 1'b1;
                    wr    <= pend_reg;
                    wdata <= ld_data;
                end
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd1_hit = regw && (wr == r1) && (wr != '0);
    assign fwd2_hit = regw && (wr == r2) && (wr != '0);
`else
    logic unused_query;
    assign unused_query = ^{r1, r2};
    assign fwd1_hit     = 1'b0;
    assign fwd2_hit     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_load_stage.sv
// Self-checking bench for wb_load_stage: directed scenarios plus a
// randomized mix, with register writes checked against an expected queue.
module tb_wb_load_stage;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_wr = '0;
    logic [31:0] in_data = '0;
    logic        in_regw = 1'b0;
    logic        in_load = 1'b0;
    logic [2:0]  in_ldop = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [4:0]  wr;
    logic [31:0] wdata;
    logic        regw;
    logic        pend;
    logic [4:0]  pend_reg;
    logic [4:0]  r1 = '0;
    logic [4:0]  r2 = '0;
    logic        fwd1_hit;
    logic        fwd2_hit;
    wb_state_e   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] exp_q[$];

    wb_load_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wr(in_wr), .in_data(in_data), .in_regw(in_regw),
        .in_load(in_load), .in_ldop(in_ldop),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wr(wr), .wdata(wdata), .regw(regw),
        .pend(pend), .pend_reg(pend_reg),
        .r1(r1), .r2(r2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference load model ----------------
    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [31:0] sb, sh;
        sb = d >> (8 * a);
        sh = d >> (16 * a[1]);
        case (op)
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd2:    return {16'h0000, sh[15:0]};
            3'd3:    return {{24{sb[7]}}, sb[7:0]};
            3'd4:    return {24'h000000, sb[7:0]};
            default: return d;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && regw) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got wr=%0d wdata=%h, expected no write", wr, wdata);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({wr, wdata} !== e) begin
                    n_fail++;
                    $display("FAIL wb_write: got wr=%0d wdata=%h, expected wr=%0d wdata=%h",
                             wr, wdata, e[36:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_alu(input logic [4:0] w, input logic [31:0] d, input logic rw);
        in_valid = 1'b1; in_load = 1'b0; in_wr = w; in_data = d; in_regw = rw; in_ldop = 3'd0;
        if (rw && w != 5'd0) exp_q.push_back({w, d});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Issues a load, returns data dly cycles after the mem_req cycle.
    task automatic send_load(input logic [4:0] w, input logic [31:0] a, input logic [2:0] op,
                             input logic [31:0] rd, input int dly, input logic rw);
        in_valid = 1'b1; in_load = 1'b1; in_wr = w; in_data = a; in_regw = rw; in_ldop = op;
        if (rw && w != 5'd0) exp_q.push_back({w, ref_load(op, a[1:0], rd)});
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = $urandom;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== (a & 32'hFFFF_FFFC) || pend !== 1'b1 ||
            pend_reg !== w || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_issue: got req=%b addr=%h pend=%b preg=%0d rdy=%b, expected 1 %h 1 %0d 0",
                     mem_req, mem_addr, pend, pend_reg, in_ready, a & 32'hFFFF_FFFC, w);
        end
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (mem_req !== 1'b0 || pend !== 1'b1 || in_ready !== 1'b0 || regw !== 1'b0) begin
                n_fail++;
                $display("FAIL load_wait: got req=%b pend=%b rdy=%b regw=%b, expected 0 1 0 0",
                         mem_req, pend, in_ready, regw);
            end
        end
        mem_rvalid = 1'b1; mem_rdata = rd;
        @(posedge clk); #1;
        mem_rvalid = 1'b0; mem_rdata = $urandom;
        n_checks++;
        if (pend !== 1'b0 || in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL load_done: got pend=%b rdy=%b state=%0d, expected 0 1 0",
                     pend, in_ready, dbg_state);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #12;
        n_checks++;
        if (regw !== 1'b0 || wr !== 5'd0 || wdata !== 32'd0 || mem_req !== 1'b0 ||
            mem_addr !== 32'd0 || pend !== 1'b0 || pend_reg !== 5'd0 || fwd1_hit !== 1'b0 ||
            fwd2_hit !== 1'b0 || in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got regw=%b wr=%0d wdata=%h req=%b addr=%h pend=%b preg=%0d rdy=%b, expected all zero, rdy=1",
                     regw, wr, wdata, mem_req, mem_addr, pend, pend_reg, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_alu_write;
        send_alu(5'd1, 32'h0000_FFF0, 1'b1);
        n_checks++;
        if (regw !== 1'b1 || wr !== 5'd1 || wdata !== 32'h0000_FFF0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL alu_write: got regw=%b wr=%0d wdata=%h, expected 1 1 0000fff0", regw, wr, wdata);
        end
        @(posedge clk); #1;
        n_checks++;
        if (regw !== 1'b0) begin
            n_fail++;
            $display("FAIL alu_pulse: got regw=%b, expected 0", regw);
        end
    endtask

    task automatic test_write_suppress;
        send_alu(5'd0, 32'hDEAD_BEEF, 1'b1);
        n_checks++;
        if (regw !== 1'b0 || wr !== 5'd1 || wdata !== 32'h0000_FFF0) begin
            n_fail++;
            $display("FAIL wr0_suppress: got regw=%b wr=%0d wdata=%h, expected 0 1 0000fff0", regw, wr, wdata);
        end
        send_alu(5'd3, 32'h1234_5678, 1'b0);
        n_checks++;
        if (regw !== 1'b0 || wr !== 5'd1 || wdata !== 32'h0000_FFF0) begin
            n_fail++;
            $display("FAIL regw0_suppress: got regw=%b wr=%0d wdata=%h, expected 0 1 0000fff0", regw, wr, wdata);
        end
        send_load(5'd0, 32'h0000_0200, LDOP_LW, 32'hCAFE_F00D, 1, 1'b1);
        send_load(5'd4, 32'h0000_0200, LDOP_LW, 32'hCAFE_F00D, 0, 1'b0);
        n_checks++;
        if (regw !== 1'b0) begin
            n_fail++;
            $display("FAIL load_suppress: got regw=%b, expected 0", regw);
        end
    endtask

    task automatic test_load_lanes;
        logic [2:0]  ops[5]  = '{LDOP_LB, LDOP_LBU, LDOP_LH, LDOP_LHU, LDOP_LW};
        logic [31:0] adrs[5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h101};
        logic [31:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_1234};
        for (int i = 0; i < 5; i++) begin
            send_load(5'd10 + 5'(i), adrs[i], ops[i], 32'h80FF_1234, i % 2, 1'b1);
            n_checks++;
            if (regw !== 1'b1 || wdata !== exps[i] || wr !== 5'd10 + 5'(i)) begin
                n_fail++;
                $display("FAIL load_lane[%0d]: got regw=%b wr=%0d wdata=%h, expected 1 %0d %h",
                         i, regw, wr, wdata, 10 + i, exps[i]);
            end
        end
    endtask

    task automatic test_long_wait;
        in_valid = 1'b1; in_load = 1'b1; in_wr = 5'd7; in_data = 32'h0000_0304;
        in_regw = 1'b1; in_ldop = LDOP_LW;
        exp_q.push_back({5'd7, 32'h0BAD_CAFE});
        @(posedge clk); #1;
        // keep a competing ALU op valid for the whole wait
        in_load = 1'b0; in_wr = 5'd9; in_data = 32'h9999_9999;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (in_ready !== 1'b0 || pend !== 1'b1 || pend_reg !== 5'd7 || regw !== 1'b0 ||
                mem_req !== (i == 0) || dbg_state !== ST_WAIT) begin
                n_fail++;
                $display("FAIL long_wait[%0d]: got rdy=%b pend=%b preg=%0d regw=%b req=%b, expected 0 1 7 0 %b",
                         i, in_ready, pend, pend_reg, regw, mem_req, i == 0);
            end
            if (i == 3) begin mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_CAFE; end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; mem_rvalid = 1'b0;
        n_checks++;
        if (regw !== 1'b1 || wr !== 5'd7 || pend !== 1'b0) begin
            n_fail++;
            $display("FAIL long_wait_wb: got regw=%b wr=%0d pend=%b, expected 1 7 0", regw, wr, pend);
        end
        @(posedge clk); #1;
        n_checks++;
        if (regw !== 1'b0) begin
            n_fail++;
            $display("FAIL long_wait_pulse: got regw=%b, expected 0", regw);
        end
    endtask

    task automatic test_reset_in_wait;
        in_valid = 1'b1; in_load = 1'b1; in_wr = 5'd3; in_data = 32'h40; in_regw = 1'b1; in_ldop = LDOP_LW;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (regw !== 1'b0 || wr !== 5'd0 || wdata !== 32'd0 || mem_req !== 1'b0 || mem_addr !== 32'd0 ||
            pend !== 1'b0 || pend_reg !== 5'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got regw=%b wr=%0d wdata=%h req=%b addr=%h pend=%b preg=%0d rdy=%b, expected zeros, rdy=1",
                     regw, wr, wdata, mem_req, mem_addr, pend, pend_reg, in_ready);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        n_checks++;
        if (regw !== 1'b0 || in_ready !== 1'b1 || pend !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: got regw=%b rdy=%b pend=%b, expected 0 1 0", regw, in_ready, pend);
        end
    endtask

    task automatic test_bypass;
        r1 = 5'd5; r2 = 5'd6;
        send_alu(5'd5, 32'h5050_5050, 1'b1);
        n_checks++;
`ifdef WB_BYPASS_EN
        if (regw !== 1'b1 || fwd1_hit !== 1'b1 || fwd2_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_r5: got regw=%b fwd1=%b fwd2=%b, expected 1 1 0", regw, fwd1_hit, fwd2_hit);
        end
`else
        if (regw !== 1'b1 || fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_off: got regw=%b fwd1=%b fwd2=%b, expected 1 0 0", regw, fwd1_hit, fwd2_hit);
        end
`endif
        r1 = 5'd0; r2 = 5'd0;
        send_alu(5'd0, 32'h0000_0001, 1'b1);
        n_checks++;
        if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_r0: got fwd1=%b fwd2=%b, expected 0 0", fwd1_hit, fwd2_hit);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 40; i++) begin
            logic [4:0]  w;
            logic        rw;
            w  = 5'($urandom_range(0, 31));
            rw = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0)
                send_alu(w, $urandom, rw);
            else
                send_load(w, $urandom, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3), rw);
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL writes_drained: got %0d pending expected writes, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_write_suppress();
        test_load_lanes();
        test_long_wait();
        test_reset_in_wait();
        test_bypass();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_load_stage.md
WB_LOAD_STAGE -- requirements
Module: wb_load_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have in_valid/in_ready, input/output, 1 bit each: upstream handshake; a transfer occurs when both are 1 at a rising edge.
REQ-004 SHALL have in_wr (in, 5), in_data (in, 32), in_regw (in, 1), in_load (in, 1) and in_ldop (in, 3): destination register, ALU result or load address, write enable, load flag and load type.
REQ-005 SHALL have mem_req (out, 1), mem_addr (out, 32), mem_rvalid (in, 1) and mem_rdata (in, 32): data-memory read port.
REQ-006 SHALL have wr (out, 5), wdata (out, 32) and regw (out, 1): register-file write port.
REQ-007 SHALL have pend (out, 1) and pend_reg (out, 5): outstanding-load scoreboard for decode stall.
REQ-008 SHALL have r1 and r2 (in, 5 each) and fwd1_hit and fwd2_hit (out, 1 each): bypass query.

Function
REQ-009 SHALL implement states IDLE and WAIT; in_ready=1 only in IDLE.
REQ-010 SHALL, for an accepted non-load, assert regw for exactly one cycle in the next cycle, with wr=in_wr and wdata=in_data; the state SHALL remain IDLE.
REQ-011 SHALL force regw=0 when in_regw=0 or in_wr=0, for both ALU results and loads.
REQ-012 SHALL, for an accepted load, enter WAIT and in the next cycle pulse mem_req for 1 cycle with mem_addr={in_data[31:2],2'b00}; pend=1 and pend_reg=in_wr from that cycle until the load writes back.
REQ-013 SHALL accept mem_rvalid in any WAIT cycle, including the mem_req cycle; regw SHALL pulse in the following cycle with the extracted data, then return to IDLE with pend=0 in that same cycle.
REQ-014 SHALL extract load data little-endian: LW returns the whole word, ignoring addr[1:0]; LH/LHU select the halfword lane by addr[1]; LB/LBU select the byte lane by addr[1:0]; LH/LB sign-extend and LHU/LBU zero-extend.
REQ-015 SHALL treat undefined in_ldop codes as LW.
REQ-016 SHALL ignore mem_rvalid in IDLE, and ignore in_valid and all in_* inputs in WAIT.
REQ-017 SHALL hold wr and wdata at their last written values when regw=0.

Reset
REQ-018 SHALL, while rst_n=0, force state=IDLE, regw=0, wr=0, wdata=0, mem_req=0, mem_addr=0, pend=0, pend_reg=0 and fwd hits=0.
REQ-019 SHALL discard a load outstanding at reset; a later mem_rvalid SHALL produce no write.

Configuration
REQ-020 SHALL, with WB_BYPASS_EN defined, drive fwdN_hit=regw && (wr==rN) && (wr!=0) combinationally; the forwarded data is wdata.
REQ-021 SHALL, without WB_BYPASS_EN, keep the r1/r2 and fwd ports present, with fwd1_hit=fwd2_hit=0.

Structure
REQ-022 SHALL place the ldop encodings (LW=000, LH=001, LHU=010, LB=011, LBU=100) and the state encodings in shared package wb_pkg.
REQ-023 SHALL implement the extraction in a combinational sub-module load_align (inputs ldop, addr[1:0], rdata[31:0]; output data[31:0]).

Verification
REQ-024 SHALL cover: in_wr=1, in_data=0x0000FFF0, in_regw=1, in_load=0 -> next cycle regw=1, wr=1, wdata=0x0000FFF0, then regw=0.
REQ-025 SHALL cover: in_wr=0, in_regw=1, any data -> regw stays 0.
REQ-026 SHALL cover: mem_rdata=0x80FF1234; LB @0x103 -> 0xFFFFFF80; LBU @0x103 -> 0x00000080; LH @0x102 -> 0xFFFF80FF; LHU @0x102 -> 0x000080FF; LW @0x101 -> mem_addr=0x100, 0x80FF1234.
REQ-027 SHALL cover: load to r7 with mem_rvalid 3 cycles after mem_req -> in_ready=0 and pend=1 with pend_reg=7 throughout; a held in_valid is not accepted; a single regw pulse follows rvalid.
REQ-028 SHALL cover: rst_n pulsed low in WAIT, then mem_rvalid=1 -> no regw, in_ready=1, pend=0.
REQ-029 SHALL cover (WB_BYPASS_EN): write to r5 with r1=5, r2=6 -> fwd1_hit=1 and fwd2_hit=0 in the regw cycle; a write to r0 with r1=0 -> fwd1_hit=0.
